// File: rtl/pix_weigh_pkg.sv
// pix_weigh_pkg: shared constants for the pixel weighting pipeline.
//   LUMA_K*    integer BT.601-style luma coefficients (sum = 256)
//   LUMA_SHIFT right shift that normalises the weighted sum to 8 bits
//   *_MSB/LSB  bit positions of the R, G, B fields inside a 24-bit pixel
package pix_weigh_pkg;

    localparam int LUMA_KR    = 77;
    localparam int LUMA_KG    = 150;
    localparam int LUMA_KB    = 29;
    localparam int LUMA_SHIFT = 8;

    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    typedef logic [23:0] pixel_t;

endpackage

// File: rtl/pix_weigh_if.sv
// pix_weigh_if: pixel stream in, chunk weights out.
//   vs_i, de_i, data_i : incoming sync / enable / RGB pixel
//   vs_o               : vs_i delayed to line up with wd_o
//   de_o, wd_o         : single-cycle strobe and chunk weight
// master = stream source / weight sink, slave = pix_weigh.
interface pix_weigh_if;
    import pix_weigh_pkg::*;

    logic       vs_i;
    logic       de_i;
    pixel_t     data_i;
    logic       vs_o;
    logic       de_o;
    logic [7:0] wd_o;

    modport master (output vs_i, de_i, data_i, input  vs_o, de_o, wd_o);
    modport slave  (input  vs_i, de_i, data_i, output vs_o, de_o, wd_o);

endinterface

// File: rtl/pix_luma.sv
// pix_luma: two-stage RGB -> luma -> threshold pipeline.
//   clk_i, rst_i   : clock, async active-high reset
//   vs_i, de_i     : sync and enable, pixel-aligned with data_i
//   data_i         : R=[23:16], G=[15:8], B=[7:0]
//   vs_o, de_o     : vs/de delayed two cycles
//   q_o            : pixel qualifies (bright for POL=1, dark for POL=0),
//                    already gated by de
module pix_luma
    import pix_weigh_pkg::*;
#(
    parameter int THRES = 128,
    parameter int POL   = 1
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   vs_i,
    input  logic   de_i,
    input  pixel_t data_i,
    output logic   vs_o,
    output logic   de_o,
    output logic   q_o
);

    localparam logic [7:0] THR = 8'(THRES);

    logic [15:0] p_r, p_g, p_b;
    logic        s1_de, s1_vs;

    logic [15:0] sum;
    logic [15:0] sum_sh;
    logic [7:0]  luma;
    logic        hit;

    // Coefficients sum to 256, so the 16-bit sum tops out at 65280.
    assign sum    = p_r + p_g + p_b;
    assign sum_sh = sum >> LUMA_SHIFT;
    assign luma   = sum_sh[7:0];
    assign hit    = (luma >= THR);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p_r   <= '0;
            p_g   <= '0;
            p_b   <= '0;
            s1_de <= 1'b0;
            s1_vs <= 1'b0;
            de_o  <= 1'b0;
            vs_o  <= 1'b0;
            q_o   <= 1'b0;
        end else begin
            p_r   <= 16'(LUMA_KR) * {8'd0, data_i[R_MSB:R_LSB]};
            p_g   <= 16'(LUMA_KG) * {8'd0, data_i[G_MSB:G_LSB]};
            p_b   <= 16'(LUMA_KB) * {8'd0, data_i[B_MSB:B_LSB]};
            s1_de <= de_i;
            s1_vs <= vs_i;
            de_o  <= s1_de;
            vs_o  <= s1_vs;
            q_o   <= s1_de & ((POL != 0) ? hit : ~hit);
        end
    end

endmodule

// File: rtl/pix_weigh.sv
// pix_weigh: counts qualifying pixels per CHUNK-pixel horizontal chunk.
//   clk_i, rst_i : pixel clock, async active-high reset
//   bus (slave)  : vs_i/de_i/data_i stream in; de_o strobe with wd_o
//                  weight (0..CHUNK) out; vs_o = vs_i delayed 3 cycles
// A chunk is emitted when full, or flushed early at a line end (de
// falling) or a vs edge while a partial chunk is pending.
module pix_weigh
    import pix_weigh_pkg::*;
#(
    parameter int CHUNK = 16,
    parameter int THRES = 128,
    parameter int POL   = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    pix_weigh_if.slave  bus
);

    localparam logic [7:0] LAST = 8'(CHUNK - 1);

    logic       l_vs, l_de, l_q;
    logic [7:0] cnt, acc;
    logic       de_d;
    logic       vs_r, de_r;
    logic [7:0] wd_r;

    pix_luma #(.THRES(THRES), .POL(POL)) u_luma (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .vs_i   (bus.vs_i),
        .de_i   (bus.de_i),
        .data_i (bus.data_i),
        .vs_o   (l_vs),
        .de_o   (l_de),
        .q_o    (l_q)
    );

    // vs_r doubles as the previous stage-2 vs, used for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt  <= '0;
            acc  <= '0;
            de_d <= 1'b0;
            vs_r <= 1'b0;
            de_r <= 1'b0;
            wd_r <= '0;
        end else begin
            vs_r <= l_vs;
            de_d <= l_de;
            de_r <= 1'b0;
            if (l_de) begin
                if (cnt == LAST) begin
                    de_r <= 1'b1;
                    wd_r <= acc + {7'd0, l_q};
                    cnt  <= '0;
                    acc  <= '0;
                end else begin
                    cnt <= cnt + 8'd1;
                    acc <= acc + {7'd0, l_q};
                end
            end else if ((de_d || (l_vs != vs_r)) && (cnt != 8'd0)) begin
                de_r <= 1'b1;
                wd_r <= acc;
                cnt  <= '0;
                acc  <= '0;
            end
        end
    end

    assign bus.vs_o = vs_r;
    assign bus.de_o = de_r;
    assign bus.wd_o = wd_r;

endmodule

// File: tb/tb_pix_weigh.sv
// tb_pix_weigh: three pix_weigh instances (CHUNK=16/POL=1, CHUNK=16/POL=0,
// CHUNK=1/POL=1) fed the same stream, checked every cycle against a
// reference model built on the input history, plus directed strobe-timing
// checks on the first two instances.
module tb_pix_weigh;

    typedef struct {
        int t;
        int wd;
    } ev_t;

    localparam int HMAX = 8192;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        vs_i = 1'b0;
    logic        de_i = 1'b0;
    logic [23:0] data_i = 24'd0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit          h_de [HMAX];
    bit          h_vs [HMAX];
    bit   [23:0] h_px [HMAX];

    int m_chunk [3] = '{16, 16, 1};
    int m_pol   [3] = '{1, 0, 1};
    int m_cnt   [3];
    int m_acc   [3];
    int e_de    [3];
    int e_wd    [3];
    int e_vs;

    logic       o_de [3];
    logic [7:0] o_wd [3];
    logic       o_vs [3];

    ev_t log0[$];
    ev_t log1[$];
    int  t0;

    pix_weigh_if bus0 ();
    pix_weigh_if bus1 ();
    pix_weigh_if bus2 ();

    assign bus0.vs_i = vs_i;  assign bus0.de_i = de_i;  assign bus0.data_i = data_i;
    assign bus1.vs_i = vs_i;  assign bus1.de_i = de_i;  assign bus1.data_i = data_i;
    assign bus2.vs_i = vs_i;  assign bus2.de_i = de_i;  assign bus2.data_i = data_i;

    assign o_de[0] = bus0.de_o;  assign o_wd[0] = bus0.wd_o;  assign o_vs[0] = bus0.vs_o;
    assign o_de[1] = bus1.de_o;  assign o_wd[1] = bus1.wd_o;  assign o_vs[1] = bus1.vs_o;
    assign o_de[2] = bus2.de_o;  assign o_wd[2] = bus2.wd_o;  assign o_vs[2] = bus2.vs_o;

    pix_weigh #(.CHUNK(16), .THRES(128), .POL(1)) dut0 (.clk_i(clk), .rst_i(rst_i), .bus(bus0));
    pix_weigh #(.CHUNK(16), .THRES(128), .POL(0)) dut1 (.clk_i(clk), .rst_i(rst_i), .bus(bus1));
    pix_weigh #(.CHUNK(1),  .THRES(128), .POL(1)) dut2 (.clk_i(clk), .rst_i(rst_i), .bus(bus2));

    always #5 clk = ~clk;

    function automatic int qual(input bit [23:0] px, input int pol);
        int r, g, b, luma;
        r = int'(px >> 16) & 255;
        g = int'(px >> 8) & 255;
        b = int'(px) & 255;
        luma = (77 * r + 150 * g + 29 * b) / 256;
        if (pol != 0) return (luma >= 128) ? 1 : 0;
        return (luma < 128) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Output after edge k reflects the pixel sampled at edge k-2 (luma
    // pipeline) and, for line-end detection, the one sampled at edge k-3.
    task automatic model(input bit r, input bit v, input bit d, input bit [23:0] px);
        int  dk, pk;
        bit  dde, dvs, pde, pvs;
        bit [23:0] dpx;
        h_de[cyc] = r ? 1'b0 : d;
        h_vs[cyc] = r ? 1'b0 : v;
        h_px[cyc] = r ? 24'd0 : px;
        dk = cyc - 2;
        pk = cyc - 3;
        dde = (dk >= 0) ? h_de[dk] : 1'b0;
        dvs = (dk >= 0) ? h_vs[dk] : 1'b0;
        dpx = (dk >= 0) ? h_px[dk] : 24'd0;
        pde = (pk >= 0) ? h_de[pk] : 1'b0;
        pvs = (pk >= 0) ? h_vs[pk] : 1'b0;
        if (r) begin
            // Reset clears the whole pipeline, so in-flight history is void.
            if (cyc >= 1) begin h_de[cyc-1] = 1'b0; h_vs[cyc-1] = 1'b0; end
            if (cyc >= 2) begin h_de[cyc-2] = 1'b0; h_vs[cyc-2] = 1'b0; end
            e_vs = 0;
        end else begin
            e_vs = dvs;
        end
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                m_cnt[i] = 0; m_acc[i] = 0; e_de[i] = 0; e_wd[i] = 0;
            end else begin
                e_de[i] = 0;
                if (dde) begin
                    m_cnt[i] += 1;
                    m_acc[i] += qual(dpx, m_pol[i]);
                    if (m_cnt[i] == m_chunk[i]) begin
                        e_de[i] = 1; e_wd[i] = m_acc[i]; m_cnt[i] = 0; m_acc[i] = 0;
                    end
                end else if ((pde || (dvs != pvs)) && m_cnt[i] != 0) begin
                    e_de[i] = 1; e_wd[i] = m_acc[i]; m_cnt[i] = 0; m_acc[i] = 0;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input bit d, input bit [23:0] px);
        ev_t ev;
        @(negedge clk);
        rst_i = r; vs_i = v; de_i = d; data_i = px;
        @(posedge clk);
        cyc++;
        model(r, v, d, px);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("de_o[%0d]", i), {31'd0, o_de[i]}, e_de[i]);
            check($sformatf("wd_o[%0d]", i), {24'd0, o_wd[i]}, e_wd[i]);
            check($sformatf("vs_o[%0d]", i), {31'd0, o_vs[i]}, e_vs);
        end
        // The registered strobe is present during the cycle after this edge.
        ev.t = cyc + 1;
        if (o_de[0] === 1'b1) begin ev.wd = int'(o_wd[0]); log0.push_back(ev); end
        if (o_de[1] === 1'b1) begin ev.wd = int'(o_wd[1]); log1.push_back(ev); end
    endtask

    task automatic begin_seg();
        log0.delete();
        log1.delete();
        t0 = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 24'd0);
    endtask

    task automatic exp_ev(input string tag, input int which, input int idx, input int t, input int wd);
        int at, aw;
        at = -1; aw = -1;
        if (which == 0 && log0.size() > idx) begin at = log0[idx].t; aw = log0[idx].wd; end
        if (which == 1 && log1.size() > idx) begin at = log1[idx].t; aw = log1[idx].wd; end
        check({tag, "_time"}, at, t);
        check({tag, "_wd"}, aw, wd);
    endtask

    initial begin
        // Reset held with inputs toggling.
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom));
        begin_seg();
        idle(6);
        check("no_strobe_after_reset", log0.size(), 0);

        // 32 white pixels: two full chunks, no trailing flush.
        begin_seg();
        for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 1'b1, 24'hFFFFFF);
        idle(8);
        check("white32_count", log0.size(), 2);
        exp_ev("white32_a", 0, 0, t0 + 18, 16);
        exp_ev("white32_b", 0, 1, t0 + 34, 16);

        // 20 alternating pixels: full chunk of 8, flush of 2.
        begin_seg();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, (i % 2 == 0) ? 24'hFFFFFF : 24'h000000);
        idle(8);
        check("alt20_count", log0.size(), 2);
        exp_ev("alt20_full", 0, 0, t0 + 18, 8);
        exp_ev("alt20_flush", 0, 1, t0 + 23, 2);

        // Threshold boundary.
        begin_seg();
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 24'h808080);
        idle(6);
        exp_ev("luma128_pol1", 0, 0, t0 + 18, 16);
        exp_ev("luma128_pol0", 1, 0, t0 + 18, 0);
        begin_seg();
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 24'h7F7F7F);
        idle(6);
        exp_ev("luma127_pol1", 0, 0, t0 + 18, 0);
        exp_ev("luma127_pol0", 1, 0, t0 + 18, 16);

        // Mid-chunk de gap.
        begin_seg();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 24'hFFFFFF);
        step(1'b0, 1'b0, 1'b0, 24'd0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 24'hFFFFFF);
        idle(8);
        check("gap_count", log0.size(), 2);
        exp_ev("gap_flush", 0, 0, t0 + 8, 5);
        exp_ev("gap_full", 0, 1, t0 + 24, 16);

        // Random stream with random vs pattern.
        begin
            bit v, d;
            v = 1'b0; d = 1'b0;
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 29) == 0) v = ~v;
                if ($urandom_range(0, 5) == 0) d = ~d;
                step(1'b0, v, d, 24'($urandom));
            end
            idle(6);
        end

        // Reset mid-line discards the partial chunk.
        begin_seg();
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 24'hFFFFFF);
        step(1'b1, 1'b0, 1'b0, 24'd0);
        step(1'b1, 1'b0, 1'b0, 24'd0);
        idle(3);
        check("rst_mid_no_strobe", log0.size(), 0);
        begin_seg();
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 24'hFFFFFF);
        idle(8);
        check("rst_mid_count", log0.size(), 1);
        exp_ev("rst_mid_full", 0, 0, t0 + 18, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
